// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and helpers for the round-robin SRAM arbiter.
//   rsp_t           registered response (valid, port index, error, write flag)
//   addr_in_range() RAM window decode
//   MemStartDefault / MemSizeDefault  default RAM window
package mem_arbiter_pkg;

  localparam logic [31:0] MemStartDefault = 32'h0000_0000;
  localparam int unsigned MemSizeDefault  = 65536;

  // Port index field sized for the largest supported configuration (8 ports).
  localparam int unsigned PortIdxW = 3;

  // wr is kept so that write responses return zero read data.
  typedef struct packed {
    logic                valid;
    logic [PortIdxW-1:0] idx;
    logic                err;
    logic                wr;
  } rsp_t;

  // Window test: the address, with its in-window offset bits cleared, must
  // equal the window base. size must be a power of two.
  function automatic logic addr_in_range(input logic [63:0] addr,
                                         input logic [63:0] start,
                                         input logic [63:0] size);
    return (addr & ~(size - 64'd1)) == start;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_if.sv
// mem_arbiter_rr_if: requester-side bus of the SRAM arbiter.
//   req/we/be/addr/wdata  per-port request fields (requester -> arbiter)
//   gnt/rvalid/err        per-port handshake and response (arbiter -> requester)
//   rdata                 shared read data, qualified by rvalid
// Modports: master = requester side, slave = arbiter side.
interface mem_arbiter_rr_if #(
  parameter int unsigned NumPorts  = 2,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
);
  logic [NumPorts-1:0]                  req;
  logic [NumPorts-1:0]                  we;
  logic [NumPorts-1:0][DataWidth/8-1:0] be;
  logic [NumPorts-1:0][AddrWidth-1:0]   addr;
  logic [NumPorts-1:0][DataWidth-1:0]   wdata;
  logic [NumPorts-1:0]                  gnt;
  logic [NumPorts-1:0]                  rvalid;
  logic [NumPorts-1:0]                  err;
  logic [DataWidth-1:0]                 rdata;

  modport master (output req, we, be, addr, wdata,
                  input  gnt, rvalid, err, rdata);
  modport slave  (input  req, we, be, addr, wdata,
                  output gnt, rvalid, err, rdata);
endinterface

// File: rtl/mem_arbiter_rr_rr_arbiter.sv
// rr_arbiter: generic round-robin arbiter with an internal pointer.
//   clk_i, rst_ni  clock, synchronous active-low reset (also masks grants)
//   req_i          request vector
//   gnt_o          one-hot grant (combinational)
//   idx_o          index of the granted requester
//   valid_o        a grant was issued this cycle
module rr_arbiter #(
  parameter int unsigned NumPorts = 2,
  localparam int unsigned IdxW    = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumPorts-1:0] req_i,
  output logic [NumPorts-1:0] gnt_o,
  output logic [IdxW-1:0]     idx_o,
  output logic                valid_o
);

  logic [IdxW-1:0] ptr_q;

  // Search upward from the pointer, wrapping at NumPorts-1.
  always_comb begin
    int unsigned     c;
    logic [IdxW-1:0] cand;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    c       = 0;
    cand    = '0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      c = 32'(ptr_q) + i;
      if (c >= NumPorts) c = c - NumPorts;
      cand = IdxW'(c);
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
    if (!rst_ni) begin
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
    end
  end

  if (NumPorts == 1) begin : g_single
    assign ptr_q = '0;
  end else begin : g_ptr
    logic [IdxW-1:0] ptr_d;

    always_comb begin
      ptr_d = ptr_q;
      if (valid_o) ptr_d = (idx_o == IdxW'(NumPorts - 1)) ? '0 : idx_o + IdxW'(1);
    end

    always_ff @(posedge clk_i) begin
      if (!rst_ni) ptr_q <= '0;
      else         ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: N-requester round-robin arbiter in front of a single-port
// SRAM with 1-cycle read latency, address-window decode and per-port response.
//   IO_CLK, IO_RST_N   clock, synchronous active-low reset
//   bus_if (slave)     requester bus: req/we/be/addr/wdata in,
//                      gnt/rvalid/err/rdata out
//   mem_*_o            RAM strobe, write, byte enables, address, write data
//   mem_rdata_i        RAM read data, valid one cycle after mem_req_o
//   perf_gnt_cnt_o     per-port 32-bit grant counters
// Optional: define MEM_ARBITER_PERF_CNT_EN to build the grant counters;
// otherwise perf_gnt_cnt_o is tied to zero.
module mem_arbiter_rr
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned          NumPorts  = 2,
  parameter int unsigned          AddrWidth = 32,
  parameter int unsigned          DataWidth = 32,
  parameter logic [AddrWidth-1:0] MemStart  = AddrWidth'(MemStartDefault),
  parameter int unsigned          MemSize   = MemSizeDefault
) (
  input  logic                         IO_CLK,
  input  logic                         IO_RST_N,
  mem_arbiter_rr_if.slave              bus_if,
  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [DataWidth/8-1:0]       mem_be_o,
  output logic [AddrWidth-1:0]         mem_addr_o,
  output logic [DataWidth-1:0]         mem_wdata_o,
  input  logic [DataWidth-1:0]         mem_rdata_i,
  output logic [NumPorts-1:0][31:0]    perf_gnt_cnt_o
);

  localparam int unsigned IdxW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

  logic [NumPorts-1:0] gnt;
  logic [IdxW-1:0]     gnt_idx;
  logic                gnt_valid;
  logic                in_rng;
  rsp_t                rsp_d, rsp_q;

  rr_arbiter #(.NumPorts(NumPorts)) u_rr (
    .clk_i   (IO_CLK),
    .rst_ni  (IO_RST_N),
    .req_i   (bus_if.req),
    .gnt_o   (gnt),
    .idx_o   (gnt_idx),
    .valid_o (gnt_valid)
  );

  assign bus_if.gnt = gnt;
  assign in_rng     = addr_in_range(64'(bus_if.addr[gnt_idx]), 64'(MemStart), 64'(MemSize));

  always_comb begin
    mem_req_o   = gnt_valid && in_rng;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (mem_req_o) begin
      mem_we_o    = bus_if.we[gnt_idx];
      mem_be_o    = bus_if.be[gnt_idx];
      mem_addr_o  = bus_if.addr[gnt_idx];
      mem_wdata_o = bus_if.wdata[gnt_idx];
    end
  end

  always_comb begin
    rsp_d       = '0;
    rsp_d.valid = gnt_valid;
    rsp_d.idx   = PortIdxW'(gnt_idx);
    rsp_d.err   = gnt_valid && !in_rng;
    rsp_d.wr    = gnt_valid && bus_if.we[gnt_idx];
  end

  always_ff @(posedge IO_CLK) begin
    if (!IO_RST_N) rsp_q <= '0;
    else           rsp_q <= rsp_d;
  end

  // Responses are also masked while reset is held so that a response
  // outstanding at reset never becomes visible.
  always_comb begin
    bus_if.rvalid = '0;
    bus_if.err    = '0;
    bus_if.rdata  = '0;
    if (IO_RST_N && rsp_q.valid) begin
      for (int unsigned k = 0; k < NumPorts; k++) begin
        if (rsp_q.idx == PortIdxW'(k)) begin
          bus_if.rvalid[k] = 1'b1;
          bus_if.err[k]    = rsp_q.err;
        end
      end
      if (!rsp_q.err && !rsp_q.wr) bus_if.rdata = mem_rdata_i;
    end
  end

`ifdef MEM_ARBITER_PERF_CNT_EN
  logic [NumPorts-1:0][31:0] cnt_q;

  always_ff @(posedge IO_CLK) begin
    if (!IO_RST_N) begin
      cnt_q <= '0;
    end else begin
      for (int unsigned k = 0; k < NumPorts; k++) begin
        if (gnt[k]) cnt_q[k] <= cnt_q[k] + 32'd1;
      end
    end
  end

  assign perf_gnt_cnt_o = cnt_q;
`else
  assign perf_gnt_cnt_o = '0;
`endif

endmodule
